// File: rtl/text_ram_dp_clr_if.sv
// Bus bundle for the dual-port text RAM: CPU port A, video port B and the
// fill-engine handshake. The RAM takes the slave view, the CPU/video side
// takes the master view.
interface text_ram_dp_clr_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 10
);
    // Port A: CPU read/write
    logic              cea;
    logic              wrea;
    logic [ADDR_W-1:0] ada;
    logic [DATA_W-1:0] dina;
    logic [DATA_W-1:0] douta;
    logic              a_ready;

    // Port B: video scan-out, read only
    logic              ceb;
    logic [ADDR_W-1:0] adb;
    logic [DATA_W-1:0] doutb;

    // Fill engine handshake
    logic              clr_start;
    logic              clr_busy;
    logic              clr_done;

    modport slave (
        input  cea, wrea, ada, dina, ceb, adb, clr_start,
        output douta, a_ready, doutb, clr_busy, clr_done
    );

    modport master (
        output cea, wrea, ada, dina, ceb, adb, clr_start,
        input  douta, a_ready, doutb, clr_busy, clr_done
    );
endinterface

// File: rtl/text_ram_dp_clr.sv
// Dual-port character/video RAM with a hardware fill engine.
// Port A is the CPU port (read/write, stalled while a fill runs); port B is
// the never-stalled video read port. Read latency is 1 or 2 cycles; any
// READ_LATENCY value other than 2 behaves as 1.
module text_ram_dp_clr #(
    parameter int              DATA_W         = 8,
    parameter int              ADDR_W         = 10,
    parameter logic [DATA_W-1:0] FILL_VALUE   = DATA_W'(8'h20),
    parameter int              READ_LATENCY   = 1,
    parameter bit              CLEAR_ON_RESET = 1'b0
) (
    input  logic               clk,
    input  logic               reset,
    text_ram_dp_clr_if.slave   bus
);

    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_FILL = 1'b1
    } fill_state_e;

    // Storage: contents start as FILL_VALUE and survive reset.
    // NOTE: the memory array has no reset branch; a reset would force it into
    // flops instead of block RAM and would also break "reset keeps contents".
    logic [DATA_W-1:0] r_mem [DEPTH] = '{default: FILL_VALUE};

    fill_state_e       r_state;
    fill_state_e       w_state_nxt;
    logic [ADDR_W-1:0] r_fill_addr;
    logic [ADDR_W-1:0] w_fill_addr_nxt;
    logic              r_done;
    logic              w_done_nxt;
    logic              r_post_reset;

    logic              w_busy;
    logic              w_a_acc;
    logic              w_a_wr;
    logic              w_mem_we;
    logic [ADDR_W-1:0] w_mem_waddr;
    logic [DATA_W-1:0] w_mem_wdata;

    logic [DATA_W-1:0] r_a_q1;
    logic [DATA_W-1:0] r_a_q2;
    logic              r_a_v1;
    logic [DATA_W-1:0] r_b_q1;
    logic [DATA_W-1:0] r_b_q2;
    logic              r_b_v1;

    // ------------------------------------------------------------------
    // Port A acceptance and the shared write path
    // ------------------------------------------------------------------
    assign w_busy  = (r_state == ST_FILL);
    assign w_a_acc = bus.cea && !w_busy;
    assign w_a_wr  = w_a_acc && bus.wrea;

    // The fill engine owns the write path while busy; otherwise port A does.
    assign w_mem_we    = w_busy || w_a_wr;
    assign w_mem_waddr = w_busy ? r_fill_addr : bus.ada;
    assign w_mem_wdata = w_busy ? FILL_VALUE  : bus.dina;

    // Single write port shared by the CPU and the fill engine.
    // NOTE: non-blocking assignment here is what gives port B the old word on
    // a same-address collision; a blocking write would leak the new value.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_mem_waddr] <= w_mem_wdata;
        end
    end

    // ------------------------------------------------------------------
    // Fill engine
    // ------------------------------------------------------------------

    // Flags the first cycle after reset so CLEAR_ON_RESET can launch a fill.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_post_reset <= 1'b1;
        end else begin
            r_post_reset <= 1'b0;
        end
    end

    // Fill FSM state, address counter and completion pulse registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_fill_addr <= '0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_fill_addr <= w_fill_addr_nxt;
            r_done      <= w_done_nxt;
        end
    end

    // Fill FSM next-state: start on request, sweep every address once, stop.
    // NOTE: every output gets a default first so no path leaves one unassigned
    // and no latch is inferred.
    always_comb begin
        w_state_nxt     = r_state;
        w_fill_addr_nxt = r_fill_addr;
        w_done_nxt      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.clr_start || (CLEAR_ON_RESET && r_post_reset)) begin
                    w_state_nxt     = ST_FILL;
                    w_fill_addr_nxt = '0;
                end
            end
            ST_FILL: begin
                // Wraps to 0 naturally after the last address.
                w_fill_addr_nxt = r_fill_addr + 1'b1;
                if (r_fill_addr == '1) begin
                    w_state_nxt = ST_IDLE;
                    w_done_nxt  = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Port A read pipeline
    // ------------------------------------------------------------------

    // First read stage: memory word, or the write data for write-through.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_a_q1 <= '0;
            r_a_v1 <= 1'b0;
        end else begin
            r_a_v1 <= w_a_acc;
            if (w_a_acc) begin
                r_a_q1 <= bus.wrea ? bus.dina : r_mem[bus.ada];
            end
        end
    end

    // Optional second stage advances only behind an accepted access.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_a_q2 <= '0;
        end else if (r_a_v1) begin
            r_a_q2 <= r_a_q1;
        end
    end

    // ------------------------------------------------------------------
    // Port B read pipeline
    // ------------------------------------------------------------------

    // First read stage; never stalled, sees fill progress as it happens.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_b_q1 <= '0;
            r_b_v1 <= 1'b0;
        end else begin
            r_b_v1 <= bus.ceb;
            if (bus.ceb) begin
                r_b_q1 <= r_mem[bus.adb];
            end
        end
    end

    // Optional second stage advances only behind an enabled read.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_b_q2 <= '0;
        end else if (r_b_v1) begin
            r_b_q2 <= r_b_q1;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.douta    = (READ_LATENCY == 2) ? r_a_q2 : r_a_q1;
    assign bus.doutb    = (READ_LATENCY == 2) ? r_b_q2 : r_b_q1;
    assign bus.a_ready  = !w_busy;
    assign bus.clr_busy = w_busy;
    assign bus.clr_done = r_done;

endmodule

// File: tb/tb_text_ram_dp_clr.sv
// Scoreboard bench for text_ram_dp_clr. Three instances: default (latency 1),
// latency 2 with fill-on-reset, and a 9-bit x 2K variant.
module tb_text_ram_dp_clr;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a;
    logic rst_b;
    logic rst_c;

    text_ram_dp_clr_if #(.DATA_W(8), .ADDR_W(10)) if_a ();
    text_ram_dp_clr_if #(.DATA_W(8), .ADDR_W(10)) if_b ();
    text_ram_dp_clr_if #(.DATA_W(9), .ADDR_W(11)) if_c ();

    text_ram_dp_clr #(
        .DATA_W(8), .ADDR_W(10), .FILL_VALUE(8'h20),
        .READ_LATENCY(1), .CLEAR_ON_RESET(1'b0)
    ) u_a (.clk(clk), .reset(rst_a), .bus(if_a.slave));

    text_ram_dp_clr #(
        .DATA_W(8), .ADDR_W(10), .FILL_VALUE(8'h20),
        .READ_LATENCY(2), .CLEAR_ON_RESET(1'b1)
    ) u_b (.clk(clk), .reset(rst_b), .bus(if_b.slave));

    text_ram_dp_clr #(
        .DATA_W(9), .ADDR_W(11), .FILL_VALUE(9'h1FF),
        .READ_LATENCY(1), .CLEAR_ON_RESET(1'b0)
    ) u_c (.clk(clk), .reset(rst_c), .bus(if_c.slave));

    typedef enum int {S_DOUTA, S_DOUTB, S_BUSY, S_READY, S_DONE} sig_e;

    typedef struct {
        int          id;
        sig_e        sig;
        logic [31:0] val;
        int          due;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int lat(input int id);
        return (id == 1) ? 2 : 1;
    endfunction

    function automatic logic [31:0] get_sig(input int id, input sig_e s);
        logic [31:0] v;
        v = '0;
        case (id)
            0: case (s)
                S_DOUTA: v = {24'b0, if_a.douta};
                S_DOUTB: v = {24'b0, if_a.doutb};
                S_BUSY:  v = {31'b0, if_a.clr_busy};
                S_READY: v = {31'b0, if_a.a_ready};
                default: v = {31'b0, if_a.clr_done};
            endcase
            1: case (s)
                S_DOUTA: v = {24'b0, if_b.douta};
                S_DOUTB: v = {24'b0, if_b.doutb};
                S_BUSY:  v = {31'b0, if_b.clr_busy};
                S_READY: v = {31'b0, if_b.a_ready};
                default: v = {31'b0, if_b.clr_done};
            endcase
            default: case (s)
                S_DOUTA: v = {23'b0, if_c.douta};
                S_DOUTB: v = {23'b0, if_c.doutb};
                S_BUSY:  v = {31'b0, if_c.clr_busy};
                S_READY: v = {31'b0, if_c.a_ready};
                default: v = {31'b0, if_c.clr_done};
            endcase
        endcase
        return v;
    endfunction

    // Expectation due 'delay' negedges from now.
    task automatic push(input int id, input sig_e s, input logic [31:0] v,
                        input int delay, input string name);
        exp_t e;
        e.id   = id;
        e.sig  = s;
        e.val  = v;
        e.due  = cyc + delay;
        e.name = name;
        sb.push_back(e);
    endtask

    // Monitor: compares every expectation that falls due on this negedge.
    always @(negedge clk) begin
        int i;
        i = 0;
        while (i < sb.size()) begin
            if (sb[i].due <= cyc) begin
                check(sb[i].name, get_sig(sb[i].id, sb[i].sig), sb[i].val);
                sb.delete(i);
            end else begin
                i++;
            end
        end
    end

    task automatic drv(input int id, input logic ace, input logic awe, input int aad,
                       input int adi, input logic bce, input int bad, input logic clr);
        case (id)
            0: begin
                if_a.cea = ace; if_a.wrea = awe; if_a.ada = aad[9:0]; if_a.dina = adi[7:0];
                if_a.ceb = bce; if_a.adb = bad[9:0]; if_a.clr_start = clr;
            end
            1: begin
                if_b.cea = ace; if_b.wrea = awe; if_b.ada = aad[9:0]; if_b.dina = adi[7:0];
                if_b.ceb = bce; if_b.adb = bad[9:0]; if_b.clr_start = clr;
            end
            default: begin
                if_c.cea = ace; if_c.wrea = awe; if_c.ada = aad[10:0]; if_c.dina = adi[8:0];
                if_c.ceb = bce; if_c.adb = bad[10:0]; if_c.clr_start = clr;
            end
        endcase
    endtask

    task automatic set_rst(input int id, input logic v);
        case (id)
            0:       rst_a = v;
            1:       rst_b = v;
            default: rst_c = v;
        endcase
    endtask

    // One cycle of stimulus; expected read data is queued with its latency.
    task automatic op(input int id, input logic ace, input logic awe, input int aad, input int adi,
                      input logic bce, input int bad, input logic clr,
                      input logic a_en, input int a_exp, input logic b_en, input int b_exp,
                      input string name);
        @(negedge clk);
        drv(id, ace, awe, aad, adi, bce, bad, clr);
        if (a_en) push(id, S_DOUTA, a_exp, lat(id), {name, "_a"});
        if (b_en) push(id, S_DOUTB, b_exp, lat(id), {name, "_b"});
    endtask

    task automatic wr_a(input int id, input int ad, input int d, input string n);
        op(id, 1, 1, ad, d, 0, 0, 0, 1, d, 0, 0, n);
    endtask

    task automatic rd_a(input int id, input int ad, input int e, input string n);
        op(id, 1, 0, ad, 0, 0, 0, 0, 1, e, 0, 0, n);
    endtask

    task automatic rd_b(input int id, input int ad, input int e, input string n);
        op(id, 0, 0, 0, 0, 1, ad, 0, 0, 0, 1, e, n);
    endtask

    task automatic nop(input int id);
        op(id, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "nop");
    endtask

    task automatic pulse_clr(input int id);
        op(id, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, "clr");
    endtask

    // Watches a fill started by the previous cycle. Mid-fill it tries a port A
    // write to address 0 and a second clr_start. With abort_at > 0, reset is
    // raised once that many busy cycles have been seen. Bounded at 5000 cycles.
    task automatic run_fill(input int id, input int abort_at,
                            output int busy_n, output int done_n, output int rdy_bad);
        logic [31:0] b, r, d;
        busy_n  = 0;
        done_n  = 0;
        rdy_bad = 0;
        for (int t = 0; t < 5000; t++) begin
            @(negedge clk);
            b = get_sig(id, S_BUSY);
            r = get_sig(id, S_READY);
            d = get_sig(id, S_DONE);
            if (b != 0) busy_n++;
            if (b == r) rdy_bad++;
            if (d != 0) done_n++;
            drv(id, 0, 0, 0, 0, 0, 0, 0);
            if (t == 50)  drv(id, 1, 1, 0, 'h099, 0, 0, 0);
            if (t == 100) drv(id, 0, 0, 0, 0, 0, 0, 1);
            if (abort_at > 0 && busy_n == abort_at) begin
                set_rst(id, 1'b1);
                break;
            end
            if (b == 0 && t > 0) break;
        end
    endtask

    int bn, dn, rb, dc;

    initial begin
        for (int id = 0; id < 3; id++) drv(id, 0, 0, 0, 0, 0, 0, 0);
        rst_a = 1'b1;
        rst_b = 1'b1;
        rst_c = 1'b1;
        repeat (3) @(negedge clk);
        for (int id = 0; id < 3; id++) begin
            push(id, S_DOUTA, 0, 1, "rst_douta");
            push(id, S_DOUTB, 0, 1, "rst_doutb");
            push(id, S_BUSY,  0, 1, "rst_busy");
            push(id, S_READY, 1, 1, "rst_ready");
            push(id, S_DONE,  0, 1, "rst_done");
        end
        @(negedge clk);
        rst_a = 1'b0;
        rst_b = 1'b0;
        rst_c = 1'b0;

        // Instance A: power-up contents
        rd_b(0, 0,    'h20, "pu_b000");
        rd_b(0, 511,  'h20, "pu_b1ff");
        rd_b(0, 1023, 'h20, "pu_b3ff");
        rd_a(0, 2,    'h20, "pu_a002");

        // Write/readback, alternating values so a latency error shows
        wr_a(0, 'h005, 'h41, "wr005");
        wr_a(0, 'h3FF, 'h5A, "wr3ff");
        rd_a(0, 'h005, 'h41, "rda005");
        rd_a(0, 'h3FF, 'h5A, "rda3ff");
        rd_a(0, 'h005, 'h41, "rda005b");
        rd_b(0, 'h005, 'h41, "rdb005");
        rd_b(0, 'h3FF, 'h5A, "rdb3ff");
        nop(0);
        push(0, S_DOUTA, 'h41, 1, "hold_a");
        push(0, S_DOUTB, 'h5A, 1, "hold_b");
        nop(0);

        // Collision: B sees the old word, then the new one
        op(0, 1, 1, 'h010, 'h7E, 1, 'h010, 0, 1, 'h7E, 1, 'h20, "collide");
        rd_b(0, 'h010, 'h7E, "post_collide");

        // Full fill with a dropped mid-fill write and an ignored restart
        wr_a(0, 'h000, 'h55, "pre000");
        wr_a(0, 'h200, 'h55, "pre200");
        wr_a(0, 'h3FF, 'h55, "pre3ff");
        pulse_clr(0);
        run_fill(0, 0, bn, dn, rb);
        check("fill_len", bn, 1024);
        check("fill_done_cnt", dn, 1);
        check("fill_ready_vs_busy", rb, 0);
        nop(0);
        push(0, S_BUSY, 0, 1, "fill_no_restart");
        push(0, S_DONE, 0, 1, "fill_done_once");
        rd_a(0, 'h000, 'h20, "fill000");
        rd_a(0, 'h200, 'h20, "fill200");
        rd_a(0, 'h3FF, 'h20, "fill3ff");
        rd_b(0, 'h000, 'h20, "fillb000");

        // Reset in the middle of a fill
        wr_a(0, 'h100, 'h55, "pre100");
        wr_a(0, 'h300, 'h55, "pre300");
        pulse_clr(0);
        run_fill(0, 300, bn, dn, rb);
        check("abort_busy_cnt", bn, 300);
        check("abort_done_cnt", dn, 0);
        push(0, S_BUSY,  0, 1, "abort_busy");
        push(0, S_READY, 1, 1, "abort_ready");
        push(0, S_DONE,  0, 1, "abort_done");
        push(0, S_DOUTA, 0, 1, "abort_douta");
        @(negedge clk);
        rst_a = 1'b0;
        dc = 0;
        repeat (20) begin
            @(negedge clk);
            if (get_sig(0, S_DONE) != 0 || get_sig(0, S_BUSY) != 0) dc++;
        end
        check("abort_quiet", dc, 0);
        rd_a(0, 'h100, 'h20, "abort100");
        rd_a(0, 'h300, 'h55, "abort300");
        nop(0);

        // Instance B: latency 2 (its fill-on-reset finished long ago)
        push(1, S_BUSY, 0, 1, "b_idle");
        wr_a(1, 'h005, 'h41, "b_wr005");
        wr_a(1, 'h3FF, 'h5A, "b_wr3ff");
        rd_a(1, 'h005, 'h41, "b_rda005");
        rd_a(1, 'h3FF, 'h5A, "b_rda3ff");
        rd_a(1, 'h005, 'h41, "b_rda005b");
        rd_b(1, 'h3FF, 'h5A, "b_rdb3ff");
        rd_b(1, 'h005, 'h41, "b_rdb005");
        rd_b(1, 'h3FF, 'h5A, "b_rdb3ffb");
        nop(1);
        nop(1);
        push(1, S_DOUTA, 'h41, 1, "b_hold_a");
        push(1, S_DOUTB, 'h5A, 1, "b_hold_b");
        nop(1);

        // Abort a fill, then CLEAR_ON_RESET must run a complete one
        wr_a(1, 'h300, 'h55, "b_pre300");
        pulse_clr(1);
        run_fill(1, 300, bn, dn, rb);
        check("b_abort_busy_cnt", bn, 300);
        check("b_abort_done_cnt", dn, 0);
        push(1, S_BUSY, 0, 1, "b_abort_busy");
        @(negedge clk);
        rst_b = 1'b0;
        run_fill(1, 0, bn, dn, rb);
        check("cor_fill_len", bn, 1024);
        check("cor_done_cnt", dn, 1);
        check("cor_ready_vs_busy", rb, 0);
        rd_a(1, 'h300, 'h20, "cor300");
        rd_a(1, 'h000, 'h20, "cor000");
        nop(1);
        nop(1);

        // Instance C: 9-bit x 2048
        rd_a(2, 'h400, 'h1FF, "c_pu400");
        wr_a(2, 'h7FF, 'h0AB, "c_wr7ff");
        rd_a(2, 'h7FF, 'h0AB, "c_rda7ff");
        rd_b(2, 'h7FF, 'h0AB, "c_rdb7ff");
        pulse_clr(2);
        run_fill(2, 0, bn, dn, rb);
        check("c_fill_len", bn, 2048);
        check("c_done_cnt", dn, 1);
        check("c_ready_vs_busy", rb, 0);
        rd_a(2, 'h7FF, 'h1FF, "c_fill7ff");
        rd_b(2, 'h000, 'h1FF, "c_fillb000");
        nop(2);

        repeat (5) @(negedge clk);
        check("sb_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/text_ram_dp_clr.md
Name: text_ram_dp_clr

Overview:
- Parametrised dual-port character/video RAM; next generation of the fixed 1Kx8 space-initialised text buffer.
- Port A is the CPU read/write port; port B is the video scan-out read-only port.
- Adds a hardware fill engine that writes FILL_VALUE to every location, with a ready/busy handshake towards the CPU port.
- Adds selectable read latency and an optional fill on reset.

Parameters:
- DATA_W, 8, data width in bits (1..18).
- ADDR_W, 10, address width; DEPTH = 2**ADDR_W words.
- FILL_VALUE, 8'h20, word written by the fill engine and the power-up contents of every location (ASCII space). Width is DATA_W.
- READ_LATENCY, 1, 1 = registered read; 2 = extra output register stage.
- CLEAR_ON_RESET, 0, 1 = a fill starts automatically on the cycle after reset deasserts.

Ports:
- clk  in  1  single clock for both ports and the fill engine.
- reset  in  1  synchronous, active-high.
- cea  in  1  port A access request.
- wrea  in  1  port A write enable (qualified by cea && a_ready).
- ada  in  ADDR_W  port A address.
- dina  in  DATA_W  port A write data.
- douta  out  DATA_W  port A read data.
- a_ready  out  1  port A accepts an access this cycle.
- ceb  in  1  port B read enable.
- adb  in  ADDR_W  port B address.
- doutb  out  DATA_W  port B read data.
- clr_start  in  1  fill request pulse.
- clr_busy  out  1  fill in progress.
- clr_done  out  1  one-cycle pulse when a fill completes.

Behaviour:
- Memory contents are FILL_VALUE at configuration.
- reset does not alter memory contents.
- reset sets douta=0, doutb=0, clr_busy=0, clr_done=0, fill address=0.
- a_ready = !clr_busy; it is 1 during and after reset unless a fill is running.
- Port A access is accepted only when cea && a_ready. An access with cea=1 while a_ready=0 is dropped; the master holds its request until a_ready=1.
- Port A read: accepted at edge N; douta valid after edge N+1 (READ_LATENCY=1) or after edge N+2 (READ_LATENCY=2).
- Port A write: write-through; douta shows dina with the same latency as a read.
- Port A idle (cea=0, or rejected): douta holds its last value.
- Port B read: ceb at edge N; doutb valid with the same latency rule. ceb=0 holds doutb.
- Port B reads are never stalled, including during a fill; they return whatever the location currently contains.
- Same-address collision, port A writing and port B reading in the same cycle: doutb returns the old data.
- Fill FSM states: IDLE and FILL.
- IDLE -> FILL on clr_start, or on the first cycle after reset when CLEAR_ON_RESET=1.
  - fill address := 0; clr_busy=1 from the next cycle.
- FILL: each cycle, write FILL_VALUE at the fill address and increment it.
  - After writing DEPTH-1, return to IDLE with clr_done=1 for exactly one cycle.
  - clr_busy is high for exactly DEPTH cycles.
- clr_start while in FILL is ignored; there is no restart.
- clr_start and an accepted port A write in the same cycle: the write executes, then the fill overwrites it.
- reset during FILL aborts immediately: FSM to IDLE, no clr_done, memory partially filled. With CLEAR_ON_RESET=1, a new full fill restarts after reset.
- The fill address wraps naturally at 2**ADDR_W. There is no off-by-one: DEPTH writes, addresses 0..DEPTH-1.
- The fill engine owns the port A write path while busy. Port A read data is not updated during a fill.

Test Plan:
- Power-up read: reset, then port B reads addresses 0, 511, 1023 -> doutb=8'h20 each, one cycle after ceb.
- Write/readback: port A writes 8'h41 at 0x005 and 8'h5A at 0x3FF, then reads them on A and B -> 8'h41 and 8'h5A. Check latency is 1 cycle, and 2 cycles with READ_LATENCY=2.
- Collision: A writes 8'h7E to 0x010 while B reads 0x010 in the same cycle -> doutb=old value 8'h20. The next B read -> 8'h7E.
- Fill: write 8'h55 to 0x000, 0x200, 0x3FF, then pulse clr_start.
  - clr_busy is high exactly 1024 cycles, a_ready=0 throughout.
  - A write requested mid-fill is not executed.
  - A second clr_start mid-fill is ignored.
  - clr_done pulses once.
  - All three addresses then read 8'h20.
- Reset mid-fill: assert reset at fill cycle 300 -> clr_busy=0 next cycle, no clr_done. Address 0x100 reads 8'h20 and a pre-written 0x300=8'h55 still reads 8'h55. Rerun with CLEAR_ON_RESET=1 -> a full 1024-cycle fill follows reset.
- Parameter sweep: DATA_W=9, ADDR_W=11, FILL_VALUE=9'h1FF -> the fill takes 2048 cycles and address 0x7FF reads 9'h1FF.
